// File: rtl/latch_mailbox_pkg.sv
// Shared types for the latch mailbox controller.
//   wr_state_t : write-FSM states (IDLE -> SETUP -> STROBE -> RELEASE)
//   wr_id_t    : writer identifier (WR_A, WR_B)
//   RD_CNT_W   : width of the read-window hold counter
package latch_mailbox_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } wr_state_t;

    typedef enum logic {
        WR_A = 1'b0,
        WR_B = 1'b1
    } wr_id_t;

    localparam int RD_CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered last-grant.
// The grant decision is combinational; the last-grant register only
// advances when the owner says the grant was taken.
// Ports:
//   Clk, RESETn : clock, synchronous active-low reset (last-grant -> B)
//   req_a/req_b : request levels
//   take        : grant is consumed this cycle when a request is present
//   gnt_valid   : at least one request present
//   gnt_b       : 1 = B wins, 0 = A wins (meaningful when gnt_valid)
module rr_arb2
    import latch_mailbox_pkg::*;
(
    input  logic Clk,
    input  logic RESETn,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic gnt_valid,
    output logic gnt_b
);

    wr_id_t last_id;

    always_comb begin
        gnt_valid = req_a | req_b;
        // On a tie the writer that did not win last time gets the slot.
        if (req_a && req_b) begin
            gnt_b = (last_id == WR_A);
        end else begin
            gnt_b = req_b;
        end
    end

    // Reset to B so that A wins the first tie after reset.
    always_ff @(posedge Clk) begin
        if (!RESETn) begin
            last_id <= WR_B;
        end else if (take && gnt_valid) begin
            last_id <= gnt_b ? WR_B : WR_A;
        end
    end

endmodule

// File: rtl/latch_mailbox_ctrl.sv
// Single-byte mailbox in front of an external octal latch (74374-style).
// Two writers arbitrate round-robin; a granted byte is placed on LATCH_D,
// clocked into the latch by a one-cycle LATCH_CEN pulse, and the writer is
// acknowledged. A reader strobes RD_REQ to open the latch outputs for
// RD_HOLD cycles, which empties the mailbox.
//
// Handshake: WR_REQ_x is a level held until WR_ACK_x (one-cycle pulse in
// the RELEASE cycle); the writer drops WR_REQ_x after seeing the ack, and a
// request dropped before grant is simply forgotten. RD_REQ is a single-cycle
// strobe, accepted only when FULL=1 and no read window is open.
//
// Ports:
//   Clk, RESETn            : clock, synchronous active-low reset
//   WR_REQ_A/B, WR_DATA_A/B: writer requests and bytes
//   WR_ACK_A/B             : capture acknowledge pulses
//   RD_REQ                 : reader strobe
//   LATCH_D, LATCH_CEN     : latch data and clock enable (rising edge captures)
//   LATCH_OCn              : latch output enable, active-low
//   FULL, IRQn, OVR        : mailbox full, reader interrupt (!FULL), sticky overrun
//   dbg_wr_state           : current write-FSM state
module latch_mailbox_ctrl
    import latch_mailbox_pkg::*;
#(
    parameter int RD_HOLD   = 2,
    parameter int OVERWRITE = 0
)
(
    input  logic       Clk,
    input  logic       RESETn,
    input  logic       WR_REQ_A,
    input  logic [7:0] WR_DATA_A,
    output logic       WR_ACK_A,
    input  logic       WR_REQ_B,
    input  logic [7:0] WR_DATA_B,
    output logic       WR_ACK_B,
    input  logic       RD_REQ,
    output logic [7:0] LATCH_D,
    output logic       LATCH_CEN,
    output logic       LATCH_OCn,
    output logic       FULL,
    output logic       IRQn,
    output logic       OVR,
    output logic [1:0] dbg_wr_state
);

    localparam logic                OVW_EN  = (OVERWRITE != 0);
    localparam logic [RD_CNT_W-1:0] RD_LOAD = RD_CNT_W'(RD_HOLD - 1);

    wr_state_t             state;
    wr_state_t             state_nxt;
    wr_id_t                cur_id;
    logic                  rd_active;
    logic [RD_CNT_W-1:0]   rd_cnt;

    logic gnt_valid;
    logic gnt_b;
    logic grant_ok;
    logic grant;
    logic rd_accept;
    logic rd_done;
    logic wr_done;
    logic full_nxt;
    logic ovr_nxt;

    rr_arb2 u_arb (
        .Clk       (Clk),
        .RESETn    (RESETn),
        .req_a     (WR_REQ_A),
        .req_b     (WR_REQ_B),
        .take      (grant_ok),
        .gnt_valid (gnt_valid),
        .gnt_b     (gnt_b)
    );

    always_comb begin
        grant_ok  = (state == IDLE) && !rd_active && (!FULL || OVW_EN);
        grant     = grant_ok && gnt_valid;
        rd_accept = RD_REQ && FULL && !rd_active;
        rd_done   = rd_active && (rd_cnt == '0);
        // Leaving STROBE is the edge at which the latch has captured the byte.
        wr_done   = (state == STROBE);

        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A byte landing on the same edge a read window closes is a new,
        // unread byte, so the write's set takes priority over the read's clear.
        full_nxt = FULL;
        ovr_nxt  = OVR;
        if (rd_done) begin
            full_nxt = 1'b0;
            ovr_nxt  = 1'b0;
        end
        if (wr_done) begin
            full_nxt = 1'b1;
            if (FULL && OVW_EN && !rd_done) begin
                ovr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!RESETn) begin
            state     <= IDLE;
            cur_id    <= WR_A;
            LATCH_D   <= 8'h00;
            LATCH_CEN <= 1'b0;
            LATCH_OCn <= 1'b1;
            WR_ACK_A  <= 1'b0;
            WR_ACK_B  <= 1'b0;
            FULL      <= 1'b0;
            IRQn      <= 1'b1;
            OVR       <= 1'b0;
            rd_active <= 1'b0;
            rd_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            // Outputs are registered from the next state so they line up
            // with the state they belong to.
            LATCH_CEN <= (state_nxt == STROBE);
            WR_ACK_A  <= (state_nxt == RELEASE) && (cur_id == WR_A);
            WR_ACK_B  <= (state_nxt == RELEASE) && (cur_id == WR_B);

            if (grant) begin
                LATCH_D <= gnt_b ? WR_DATA_B : WR_DATA_A;
                cur_id  <= gnt_b ? WR_B : WR_A;
            end

            if (rd_accept) begin
                rd_active <= 1'b1;
                rd_cnt    <= RD_LOAD;
                LATCH_OCn <= 1'b0;
            end else if (rd_active) begin
                if (rd_cnt == '0) begin
                    rd_active <= 1'b0;
                    LATCH_OCn <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt - RD_CNT_W'(1);
                end
            end

            FULL <= full_nxt;
            IRQn <= !full_nxt;
            OVR  <= ovr_nxt;
        end
    end

    assign dbg_wr_state = state;

endmodule

// File: tb/tb_latch_mailbox_ctrl.sv
// Bench for latch_mailbox_ctrl: two instances (OVERWRITE=0 and 1) share one
// stimulus set, selected by sel. A synchronous 74374 model captures
// LATCH_D on a rising LATCH_CEN; its edge detector resets high.
module tb_latch_mailbox_ctrl;
    import latch_mailbox_pkg::*;

    localparam int RD_HOLD = 2;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       RESETn;
    logic       sel;
    logic       wr_req_a, wr_req_b, rd_req;
    logic [7:0] wr_data_a, wr_data_b;

    logic       ack_a0, ack_b0, cen0, ocn0, full0, irqn0, ovr0;
    logic       ack_a1, ack_b1, cen1, ocn1, full1, irqn1, ovr1;
    logic [7:0] d0, d1;
    logic [1:0] st0, st1;

    latch_mailbox_ctrl #(.RD_HOLD(RD_HOLD), .OVERWRITE(0)) dut0 (
        .Clk(Clk), .RESETn(RESETn),
        .WR_REQ_A(wr_req_a & !sel), .WR_DATA_A(wr_data_a), .WR_ACK_A(ack_a0),
        .WR_REQ_B(wr_req_b & !sel), .WR_DATA_B(wr_data_b), .WR_ACK_B(ack_b0),
        .RD_REQ(rd_req & !sel), .LATCH_D(d0), .LATCH_CEN(cen0), .LATCH_OCn(ocn0),
        .FULL(full0), .IRQn(irqn0), .OVR(ovr0), .dbg_wr_state(st0)
    );

    latch_mailbox_ctrl #(.RD_HOLD(RD_HOLD), .OVERWRITE(1)) dut1 (
        .Clk(Clk), .RESETn(RESETn),
        .WR_REQ_A(wr_req_a & sel), .WR_DATA_A(wr_data_a), .WR_ACK_A(ack_a1),
        .WR_REQ_B(wr_req_b & sel), .WR_DATA_B(wr_data_b), .WR_ACK_B(ack_b1),
        .RD_REQ(rd_req & sel), .LATCH_D(d1), .LATCH_CEN(cen1), .LATCH_OCn(ocn1),
        .FULL(full1), .IRQn(irqn1), .OVR(ovr1), .dbg_wr_state(st1)
    );

    wire       ack_a = sel ? ack_a1 : ack_a0;
    wire       ack_b = sel ? ack_b1 : ack_b0;
    wire       cen   = sel ? cen1   : cen0;
    wire       ocn   = sel ? ocn1   : ocn0;
    wire       full  = sel ? full1  : full0;
    wire       irqn  = sel ? irqn1  : irqn0;
    wire       ovr   = sel ? ovr1   : ovr0;
    wire [7:0] ld    = sel ? d1     : d0;
    wire [1:0] st    = sel ? st1    : st0;

    // ---------------- 74374 latch model ----------------
    logic [7:0] q_latch  = 8'h00;
    logic       cen_prev = 1'b1;
    always @(posedge Clk) begin
        if (!RESETn) begin
            cen_prev <= 1'b1;
        end else begin
            cen_prev <= cen;
            if (cen && !cen_prev) q_latch <= ld;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic       m_full, m_ovr, m_last_b;
    logic [7:0] m_q = 8'h00;
    logic [7:0] exp_q[$];
    logic       id_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge Clk);
        RESETn   = 1'b0;
        wr_req_a = 1'b0;
        wr_req_b = 1'b0;
        rd_req   = 1'b0;
        repeat (2) @(negedge Clk);
        RESETn   = 1'b1;
        m_full   = 1'b0;
        m_ovr    = 1'b0;
        m_last_b = 1'b1;
    endtask

    // Reader: a strobe empties a full mailbox after RD_HOLD enabled cycles,
    // and is ignored on an empty one.
    task automatic rd_txn();
        int n;
        rd_req = 1'b1;
        @(negedge Clk);
        rd_req = 1'b0;
        if (m_full) begin
            n = 0;
            while (ocn == 1'b0 && n < 20) begin
                n++;
                @(negedge Clk);
            end
            check_eq("rd_window_len", n, RD_HOLD);
            check_eq("rd_full_clr", full, 0);
            check_eq("rd_irqn_set", irqn, 1);
            check_eq("rd_ovr_clr", ovr, 0);
            check_eq("rd_latch_q", q_latch, m_q);
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            repeat (3) begin
                check_eq("rd_ignored_ocn", ocn, 1);
                check_eq("rd_ignored_full", full, 0);
                @(negedge Clk);
            end
        end
    endtask

    // Writers: raises the requested levels and follows them to their acks,
    // servicing the mailbox with a read whenever the model says a write
    // must stall.
    task automatic write_txn(input logic ra, input logic rb,
                             input logic [7:0] da, input logic [7:0] db);
        logic first_b;
        int   n;
        first_b = (ra && rb) ? !m_last_b : rb;
        exp_q.push_back(first_b ? db : da);
        id_q.push_back(first_b);
        if (ra && rb) begin
            exp_q.push_back(first_b ? da : db);
            id_q.push_back(!first_b);
        end
        wr_req_a  = ra;
        wr_data_a = da;
        wr_req_b  = rb;
        wr_data_b = db;
        while (exp_q.size() > 0) begin
            if (m_full && !sel) begin
                repeat (6) begin
                    @(negedge Clk);
                    check_eq("stall_no_ack", {ack_a, ack_b}, 2'b00);
                end
                rd_txn();
            end
            n = 0;
            do begin
                @(negedge Clk);
                n++;
            end while (!(ack_a || ack_b) && n < 40);
            if (!(ack_a || ack_b)) begin
                check_eq("ack_timeout", 0, 1);
                wr_req_a = 1'b0;
                wr_req_b = 1'b0;
                exp_q.delete();
                id_q.delete();
                return;
            end
            check_eq("ack_writer", ack_b, id_q[0]);
            check_eq("ack_single", ack_a & ack_b, 0);
            m_q      = exp_q.pop_front();
            m_last_b = id_q.pop_front();
            m_ovr    = m_ovr | m_full;
            m_full   = 1'b1;
            check_eq("wr_latch_q", q_latch, m_q);
            check_eq("wr_full", full, 1);
            check_eq("wr_irqn", irqn, 0);
            check_eq("wr_ovr", ovr, m_ovr);
            if (m_last_b) wr_req_b = 1'b0;
            else          wr_req_a = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r;
        sel = 1'b0; RESETn = 1'b0;
        wr_req_a = 1'b0; wr_req_b = 1'b0; rd_req = 1'b0;
        wr_data_a = 8'h00; wr_data_b = 8'h00;
        apply_reset();

        // reset state
        check_eq("rst_cen", cen, 0);
        check_eq("rst_ocn", ocn, 1);
        check_eq("rst_d", ld, 8'h00);
        check_eq("rst_full", full, 0);
        check_eq("rst_irqn", irqn, 1);
        check_eq("rst_ovr", ovr, 0);
        check_eq("rst_acks", {ack_a, ack_b}, 2'b00);
        check_eq("rst_state", st, IDLE);

        // single write, cycle by cycle
        wr_req_a = 1'b1; wr_data_a = 8'h5A;
        @(negedge Clk);
        check_eq("c1_state", st, SETUP);
        check_eq("c1_cen", cen, 0);
        check_eq("c1_d", ld, 8'h5A);
        @(negedge Clk);
        check_eq("c2_state", st, STROBE);
        check_eq("c2_cen", cen, 1);
        check_eq("c2_ack", ack_a, 0);
        @(negedge Clk);
        check_eq("c3_state", st, RELEASE);
        check_eq("c3_cen", cen, 0);
        check_eq("c3_ack_a", ack_a, 1);
        check_eq("c3_q", q_latch, 8'h5A);
        check_eq("c3_full", full, 1);
        check_eq("c3_irqn", irqn, 0);
        wr_req_a = 1'b0;
        @(negedge Clk);
        check_eq("c4_state", st, IDLE);
        check_eq("c4_ack_a", ack_a, 0);
        m_full = 1'b1; m_q = 8'h5A; m_last_b = 1'b0;
        rd_txn();

        // simultaneous writers: A first after reset, then rotation
        apply_reset();
        write_txn(1'b1, 1'b1, 8'h11, 8'h22);
        rd_txn();
        write_txn(1'b1, 1'b0, 8'h66, 8'h00);
        rd_txn();
        write_txn(1'b1, 1'b1, 8'h11, 8'h22);

        // stalled writer while full, released by a read
        write_txn(1'b0, 1'b1, 8'h00, 8'h33);
        check_eq("stall_q", q_latch, 8'h33);

        // second strobe inside an open window does not extend it
        rd_req = 1'b1;
        @(negedge Clk);
        check_eq("win_open", ocn, 0);
        @(negedge Clk);
        check_eq("win_second", ocn, 0);
        rd_req = 1'b0;
        @(negedge Clk);
        check_eq("win_closed", ocn, 1);
        check_eq("win_full", full, 0);
        @(negedge Clk);
        check_eq("win_stays_closed", ocn, 1);
        m_full = 1'b0; m_ovr = 1'b0;
        rd_txn();

        // reset during STROBE
        wr_req_a = 1'b1; wr_data_a = 8'h99;
        @(negedge Clk);
        check_eq("ab_setup", st, SETUP);
        @(negedge Clk);
        check_eq("ab_strobe", cen, 1);
        RESETn = 1'b0; wr_req_a = 1'b0;
        @(negedge Clk);
        check_eq("ab_cen", cen, 0);
        check_eq("ab_full", full, 0);
        check_eq("ab_ack", {ack_a, ack_b}, 2'b00);
        check_eq("ab_q", q_latch, m_q);
        check_eq("ab_state", st, IDLE);
        RESETn = 1'b1;
        m_full = 1'b0; m_ovr = 1'b0; m_last_b = 1'b1;

        // overwrite instance
        sel = 1'b1;
        apply_reset();
        write_txn(1'b0, 1'b1, 8'h00, 8'h55);
        write_txn(1'b1, 1'b0, 8'h44, 8'h00);
        check_eq("ovw_ovr", ovr, 1);
        check_eq("ovw_q", q_latch, 8'h44);
        rd_txn();

        // randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            apply_reset();
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 3);
                if (r <= 1) begin
                    r = $urandom_range(1, 3);
                    write_txn(r[0], r[1], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end else if (r == 2) begin
                    rd_txn();
                end else begin
                    repeat ($urandom_range(1, 5)) @(negedge Clk);
                    check_eq("idle_full", full, m_full);
                    check_eq("idle_ovr", ovr, m_ovr);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/latch_mailbox_ctrl.md
LATCH_MAILBOX_CTRL -- requirements
Module: latch_mailbox_ctrl

Interface
REQ-001 The block SHALL have parameter RD_HOLD, default 2, giving the number of Clk cycles the latch output is enabled per read (legal 1..15).
REQ-002 The block SHALL have parameter OVERWRITE, default 0, where 1 allows writes into a full mailbox.
REQ-003 The block SHALL have port Clk, input, 1 bit, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port RESETn, input, 1 bit, reset, synchronous, active-low.
REQ-005 The block SHALL have port WR_REQ_A, input, 1 bit, writer A level request, held until acknowledged.
REQ-006 The block SHALL have port WR_DATA_A, input, 8 bits, writer A byte.
REQ-007 The block SHALL have port WR_ACK_A, output, 1 bit, one-cycle pulse when writer A's byte has been captured.
REQ-008 The block SHALL have ports WR_REQ_B, WR_DATA_B and WR_ACK_B, identical to the A ports, for writer B.
REQ-009 The block SHALL have port RD_REQ, input, 1 bit, single-cycle reader strobe.
REQ-010 The block SHALL have port LATCH_D, output, 8 bits, data to the octal latch.
REQ-011 The block SHALL have port LATCH_CEN, output, 1 bit, latch clock-enable; the latch captures on a low-to-high transition.
REQ-012 The block SHALL have port LATCH_OCn, output, 1 bit, latch output enable, active-low.
REQ-013 The block SHALL have ports FULL (output, 1 bit, mailbox holds an unread byte), IRQn (output, 1 bit, active-low reader interrupt, equal to !FULL) and OVR (output, 1 bit, sticky overrun flag).

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The write FSM SHALL have the states IDLE, SETUP, STROBE and RELEASE.
REQ-016 LATCH_CEN SHALL be 1 only in STROBE.
REQ-017 A write SHALL be granted in IDLE when a request is present, no read window is active, and either FULL=0 or OVERWRITE=1.
REQ-018 On grant at edge k the FSM SHALL enter SETUP and register the granted writer's data into LATCH_D.
REQ-019 The FSM SHALL enter STROBE at edge k+1 and RELEASE at edge k+2; at edge k+2, FULL SHALL be set and the granted writer's WR_ACK SHALL be 1 for exactly the RELEASE cycle.
REQ-020 The FSM SHALL return to IDLE at edge k+3, giving a back-to-back write throughput of one byte per 4 cycles.
REQ-021 LATCH_D SHALL hold its value from SETUP until the next grant.
REQ-022 Arbitration SHALL be round-robin: on simultaneous requests the writer not granted last wins, and after reset A wins first.
REQ-023 With OVERWRITE=0 and FULL=1, write requests SHALL stall without an ack.
REQ-024 With OVERWRITE=1, a write completing while FULL=1 SHALL set OVR.
REQ-025 RD_REQ SHALL be accepted only when FULL=1 and no read window is active; otherwise it is ignored with no state change.
REQ-026 An accepted RD_REQ SHALL drive LATCH_OCn=0 starting the next cycle, for exactly RD_HOLD cycles.
REQ-027 At the edge that ends the read window, FULL and OVR SHALL be cleared and IRQn raised.
REQ-028 A read MAY be accepted during RELEASE, since FULL is already 1.
REQ-029 Writes SHALL NOT be granted while a read window is active; a pending request is granted in the first IDLE cycle after the window ends.
REQ-030 A request dropped before grant SHALL be forgotten.

Reset
REQ-031 With RESETn=0 at an edge, the block SHALL enter IDLE and set LATCH_CEN=0, LATCH_OCn=1, LATCH_D=0x00, FULL=0, IRQn=1, OVR=0, both acks 0, and the last-grant indicator to B.
REQ-032 Reset SHALL abort any write or read in progress with no ack.
REQ-033 Because LATCH_CEN is held 0 during reset and SETUP, a downstream latch whose edge detector resets high SHALL NOT see a spurious capture.

Structure
REQ-034 Package latch_mailbox_pkg SHALL hold the write-FSM state enum, the writer-id enum (WR_A, WR_B) and the RD_HOLD counter width constant (4).
REQ-035 The block SHALL contain one sub-module, rr_arb2, a two-requester round-robin arbiter with a registered last-grant; all else is inline.

Verification
REQ-036 Reset, then WR_REQ_A with 0x5A -> SETUP/STROBE/RELEASE over cycles 1-3, LATCH_CEN high only in cycle 2, WR_ACK_A in cycle 3, the bench's synchronous 74374 model Q=0x5A, FULL=1, IRQn=0.
REQ-037 A (0x11) and B (0x22) request on the same cycle, reads interleaved -> A acked first, B second; a repeat of the test grants B first.
REQ-038 OVERWRITE=0 with FULL=1, B requests 0x33 -> no ack while full; RD_REQ -> LATCH_OCn low for 2 cycles, FULL clears, then B acked and latch holds 0x33.
REQ-039 OVERWRITE=1 with FULL=1, A writes 0x44 -> ack, OVR=1, latch holds 0x44; read clears OVR and FULL.
REQ-040 RD_REQ with FULL=0, and a second RD_REQ during an active window -> both ignored, LATCH_OCn stays at its current value, no flag change.
REQ-041 RESETn low during STROBE -> next cycle LATCH_CEN=0, FULL=0, no WR_ACK, and the latch value is unchanged from before the write.
